prefix_adder_pipe: RTL and testbench

Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor with valid/ready handshakes on both sides and an internal accumulator mode. It is the successor to the fixed 8-bit combinational prefix adder in tt_um_top. Registers split the prefix tree into PIPE_STAGES stages. Backpressure stalls the whole pipeline, and an interlock protects the accumulator read-after-write dependency.

---
 rtl/prefix_adder_pipe.sv | 172 +++++++++++++++++
 tb/tb_prefix_adder_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with accumulator.
// Prefix levels are spread evenly across PIPE_STAGES registers.
module prefix_adder_pipe #(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc_value
);

  localparam int LG = $clog2(WIDTH);
  localparam int NL = 2 * LG - 1;
  localparam int P  = PIPE_STAGES;

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] x;
    logic             cin;
    logic             am;
    logic             bm;
    logic             acc;
  } stg_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  // Levels 0..LG-1 are the up-sweep, the rest the down-sweep.
  function automatic stg_t bk_level(stg_t s, int l);
    stg_t r;
    int   d;
    int   sp;
    logic hit;
    r  = s;
    d  = (l < LG) ? l : 2 * LG - 2 - l;
    sp = 1 << d;
    for (int i = 0; i < WIDTH; i++) begin
      if (l < LG)
        hit = ((i + 1) % (2 * sp)) == 0;
      else
        hit = (((i + 1) % (2 * sp)) == sp) &&
              (i >= 2 * sp);
      if (hit) begin
        r.g[i] = s.g[i] | (s.p[i] & s.g[i-sp]);
        r.p[i] = s.p[i] & s.p[i-sp];
      end
    end
    return r;
  endfunction

  function automatic stg_t run_seg(stg_t s, int k);
    stg_t r;
    r = s;
    for (int l = 0; l < NL; l++) begin
      if (l >= (k * NL) / P && l < ((k + 1) * NL) / P)
        r = bk_level(r, l);
    end
    return r;
  endfunction

  function automatic res_t fin(stg_t s);
    res_t r;
    r.sum  = s.x ^ {s.g[WIDTH-2:0], s.cin};
    r.cout = s.g[WIDTH-1];
    r.ovf  = (s.am == s.bm) &&
             (r.sum[WIDTH-1] != s.am);
    return r;
  endfunction

  stg_t             stg_q [P];
  stg_t             stg_d [P];
  logic             vld_q [P];
  logic             vld_d [P];
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] be;
  logic             ce;
  stg_t             gen;
  res_t             res;
  res_t             res_in;
  logic             stall, adv, accept, enter;

  assign out_valid = vld_q[P-1];
  assign stall     = out_valid && !out_ready;
  assign adv       = !stall;
  assign in_ready  = rst_n && !stall &&
                     !(busy_q && in_op[1]);
  assign accept    = in_valid && in_ready;

  always_comb begin
    be = in_b;
    ce = in_cin;
    case (in_op)
      2'b00: begin be = in_b;  ce = in_cin; end
      2'b01: begin be = ~in_b; ce = 1'b1;   end
      2'b10: begin be = acc_q; ce = 1'b0;   end
      default: begin be = '0;  ce = 1'b0;   end
    endcase
    gen.x    = in_a ^ be;
    gen.p    = in_a ^ be;
    gen.g    = in_a & be;
    gen.g[0] = (in_a[0] & be[0]) | (gen.p[0] & ce);
    gen.cin  = ce;
    gen.am   = in_a[WIDTH-1];
    gen.bm   = be[WIDTH-1];
    gen.acc  = in_op[1];
  end

  always_comb begin
    stg_d[0] = run_seg(gen, 0);
    vld_d[0] = accept;
    for (int k = 1; k < P; k++) begin
      stg_d[k] = run_seg(stg_q[k-1], k);
      vld_d[k] = vld_q[k-1];
    end
  end

  assign res       = fin(stg_q[P-1]);
  assign res_in    = fin(stg_d[P-1]);
  assign out_sum   = res.sum;
  assign out_cout  = res.cout;
  assign out_ovf   = res.ovf;
  assign acc_value = acc_q;

  // An ACC/LOAD entering the output register retires the interlock.
  assign enter = adv && vld_d[P-1] && stg_d[P-1].acc;

  always_comb begin
    acc_d  = enter ? res_in.sum : acc_q;
    busy_d = busy_q;
    if (enter)
      busy_d = 1'b0;
    if (accept && in_op[1] && (P > 1))
      busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < P; k++) begin
        stg_q[k] <= '0;
        vld_q[k] <= 1'b0;
      end
      acc_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      if (adv) begin
        for (int k = 0; k < P; k++) begin
          stg_q[k] <= stg_d[k];
          vld_q[k] <= vld_d[k];
        end
      end
      acc_q  <= acc_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed table, corner
// sequences and a random scoreboard run.
module tb_prefix_adder_pipe;

  localparam int W = 8;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_cin;
  logic [1:0]   in_op;
  logic [W-1:0] in_a, in_b, out_sum, acc_value;
  logic         out_valid, out_ready, out_cout, out_ovf;

  prefix_adder_pipe #(.WIDTH(W), .PIPE_STAGES(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .out_ovf(out_ovf), .acc_value(acc_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  int           n_out  = 0;
  res_t         q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] acc_m;
  logic         stall_prev;
  logic [W-1:0] held_sum;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Scoreboard: reference is plain modular arithmetic.
  logic [W:0]   r;
  logic [W-1:0] be;
  res_t         e;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      q.delete();
      acc_m      = '0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("hold_sum", out_sum, held_sum);
      if (out_valid && !out_ready)
        chk("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0d expected none",
                   out_sum);
        end else begin
          e = q.pop_front();
          chk("sb_sum", out_sum, e.sum);
          chk("sb_cout", out_cout, e.cout);
          chk("sb_ovf", out_ovf, e.ovf);
        end
        hist.push_back(out_sum);
        n_out++;
      end
      if (in_valid && in_ready) begin
        case (in_op)
          2'b00: begin
            be = in_b;
            r = (W+1)'(in_a) + (W+1)'(in_b) + (W+1)'(in_cin);
          end
          2'b01: begin
            be = ~in_b;
            r = (W+1)'(in_a) + (W+1)'(be) + (W+1)'(1);
          end
          2'b10: begin
            be = acc_m;
            r = (W+1)'(in_a) + (W+1)'(acc_m);
          end
          default: begin
            be = '0;
            r = (W+1)'(in_a);
          end
        endcase
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (in_a[W-1] == be[W-1]) &&
                 (r[W-1] != in_a[W-1]);
        if (in_op[1])
          acc_m = r[W-1:0];
        q.push_back(e);
      end
      stall_prev = out_valid && !out_ready;
      held_sum   = out_sum;
    end
  end

  task automatic send(input logic [1:0] op,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic c,
                      output int w);
    logic ok;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    w        = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      w++;
      if (w > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got %0d cycles expected accept",
                 w);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
  endtask

  task automatic drain(input int target);
    int t;
    t = 0;
    while (n_out < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_count", n_out, target);
    @(posedge clk);
    #1;
  endtask

  vec_t tv[8];
  int   w, n, base, hb;
  logic done;

  initial begin
    tv[0] = '{2'd0, 8'd2,   8'd5,   1'b0, 8'd7,   1'b0, 1'b0};
    tv[1] = '{2'd0, 8'd2,   8'd133, 1'b0, 8'd135, 1'b0, 1'b0};
    tv[2] = '{2'd0, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
    tv[3] = '{2'd0, 8'd100, 8'd100, 1'b0, 8'd200, 1'b0, 1'b1};
    tv[4] = '{2'd0, 8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b0};
    tv[5] = '{2'd1, 8'd5,   8'd7,   1'b0, 8'd254, 1'b0, 1'b0};
    tv[6] = '{2'd1, 8'd128, 8'd1,   1'b0, 8'd127, 1'b1, 1'b1};
    tv[7] = '{2'd1, 8'd9,   8'd9,   1'b0, 8'd0,   1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_op     = 2'b00;
    in_a      = 8'd3;
    in_b      = 8'd4;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    done      = 1'b0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_acc", acc_value, 0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      send(tv[i].op, tv[i].a, tv[i].b, tv[i].cin, w);
      wait_valid(n);
      chk($sformatf("lat_%0d", i), n, P);
      chk($sformatf("sum_%0d", i), out_sum, tv[i].sum);
      chk($sformatf("cout_%0d", i), out_cout, tv[i].cout);
      chk($sformatf("ovf_%0d", i), out_ovf, tv[i].ovf);
      @(posedge clk);
      #1;
    end

    base = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(2'b00, W'($urandom), W'($urandom), 1'b0, w);
      end
      begin
        n = 0;
        while (n_out < base + 2 && n < 100) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain(base + 6);
    chk("bp_queue_empty", q.size(), 0);

    hb = hist.size();
    send(2'b11, 8'd10, 8'd0, 1'b0, w);
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_a     = 8'd3;
    @(negedge clk);
    chk("acc_interlock1", in_ready, 0);
    send(2'b10, 8'd3, 8'd0, 1'b0, w);
    chk("acc_wait1", w, 0);
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_a     = 8'd250;
    @(negedge clk);
    chk("acc_interlock2", in_ready, 0);
    send(2'b10, 8'd250, 8'd0, 1'b0, w);
    chk("acc_wait2", w, 0);
    send(2'b00, 8'd1, 8'd1, 1'b0, w);
    chk("add_while_busy", w, 0);
    drain(n_out + (hb + 4 - hist.size()));
    chk("acc_r0", hist[hb], 10);
    chk("acc_r1", hist[hb+1], 13);
    chk("acc_r2", hist[hb+2], 7);
    chk("acc_r3", hist[hb+3], 2);
    chk("acc_value_7", acc_value, 7);

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(2'b00, 8'd1, 8'd2, 1'b0, w);
    send(2'b00, 8'd3, 8'd4, 1'b0, w);
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_a     = 8'd5;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_acc", acc_value, 0);
    @(negedge clk);
    chk("midrst_valid2", out_valid, 0);
    @(posedge clk);
    #1;
    hb = hist.size();
    base = n_out;
    send(2'b11, 8'd4, 8'd0, 1'b0, w);
    send(2'b10, 8'd4, 8'd0, 1'b0, w);
    drain(base + 2);
    chk("midrst_r0", hist[hb], 4);
    chk("midrst_r1", hist[hb+1], 8);
    chk("midrst_acc8", acc_value, 8);

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end else begin
            send(2'($urandom), W'($urandom), W'($urandom),
                 1'($urandom), w);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("rand_queue_empty", q.size(), 0);
    chk("rand_acc", acc_value, acc_m);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
